// File: rtl/hazard_ctrl.sv
// Hazard controller: stall/flush sequencing, EX operand forwarding and a memory-hold FSM with overrun flag.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int unsigned MAX_HOLD = 255,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RS1_E,
  input  logic [4:0]       RS2_E,
  input  logic [4:0]       RD_E,
  input  logic             RegWriteE,
  input  logic             ResultSrcE,
  input  logic [4:0]       RD_M,
  input  logic [4:0]       RD_W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             hold_req,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             hold_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] hold_cnt_total
`endif
);

  typedef enum logic {RUN, HOLD} state_e;

  localparam logic [15:0] MaxHoldL = 16'(MAX_HOLD);

  state_e      fsm_q, fsm_d;
  logic [15:0] hold_ctr_q, hold_ctr_d;
  logic        hold_timeout_q, hold_timeout_d;
  logic        ld_use;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWriteM && (RD_M != 5'd0) && (RD_M == rs))      fwd_sel = 2'b10;
    else if (RegWriteW && (RD_W != 5'd0) && (RD_W == rs)) fwd_sel = 2'b01;
    else                                                   fwd_sel = 2'b00;
  endfunction

  assign ld_use = ResultSrcE && RegWriteE && (RD_E != 5'd0) &&
                  ((RD_E == RS1_D) || (RD_E == RS2_D));

  // A hold cycle is any cycle with hold_req high: entry is combinational from RUN,
  // and the pipe resumes RUN behaviour in the first cycle hold_req is low.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!rst) begin
      ForwardAE = fwd_sel(RS1_E);
      ForwardBE = fwd_sel(RS2_E);
      if (hold_req) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else begin
        StallF = ld_use;
        StallD = ld_use;
        FlushD = PCSrcE;
        FlushE = PCSrcE | ld_use;
      end
    end
  end

  always_comb begin
    fsm_d          = fsm_q;
    hold_ctr_d     = hold_ctr_q;
    hold_timeout_d = hold_timeout_q;
    if (hold_req) begin
      fsm_d = HOLD;
      if (fsm_q == RUN)           hold_ctr_d = 16'd1;
      else if (hold_ctr_q != '1)  hold_ctr_d = hold_ctr_q + 16'd1;
      if (hold_ctr_d == MaxHoldL) hold_timeout_d = 1'b1;
    end else begin
      fsm_d      = RUN;
      hold_ctr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q          <= RUN;
      hold_ctr_q     <= '0;
      hold_timeout_q <= 1'b0;
    end else begin
      fsm_q          <= fsm_d;
      hold_ctr_q     <= hold_ctr_d;
      hold_timeout_q <= hold_timeout_d;
    end
  end

  assign hold_timeout = hold_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, hold_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(StallD);
      flush_cnt_q <= flush_cnt_q + CNT_W'(FlushE);
      hold_cnt_q  <= hold_cnt_q + CNT_W'(hold_req);
    end
  end

  assign stall_cnt      = stall_cnt_q;
  assign flush_cnt      = flush_cnt_q;
  assign hold_cnt_total = hold_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed test-plan steps plus randomized traffic against a rule-level model.
module tb_hazard_ctrl;
  localparam int unsigned MAXH = 4;
  localparam int unsigned CW   = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
  logic       RegWriteE, ResultSrcE, RegWriteM, RegWriteW, PCSrcE, hold_req;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, hold_timeout;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] stall_cnt, flush_cnt, hold_cnt_total;
`endif

  hazard_ctrl #(.MAX_HOLD(MAXH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .RD_M(RD_M), .RD_W(RD_W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .hold_req(hold_req),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .hold_timeout(hold_timeout)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .hold_cnt_total(hold_cnt_total)
`endif
  );

  always #5 clk = ~clk;

  int unsigned ncomp = 0;
  int unsigned nfail = 0;

  // Reference state: length of the current hold burst, sticky flag, counters.
  int unsigned   hold_run;
  bit            tmo_m;
  logic [CW-1:0] m_stall, m_flush, m_hold;

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (RegWriteM && RD_M != 0 && RD_M == rs) return 2'b10;
    if (RegWriteW && RD_W != 0 && RD_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  // {StallF, StallD, StallE, StallM, FlushD, FlushE}
  function automatic logic [5:0] ctl_ref();
    logic ld;
    ld = ResultSrcE && RegWriteE && RD_E != 0 && (RD_E == RS1_D || RD_E == RS2_D);
    if (rst)      return 6'b000000;
    if (hold_req) return 6'b111100;
    return {ld, ld, 1'b0, 1'b0, PCSrcE, PCSrcE | ld};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("ctrl", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE}), 32'(ctl_ref()));
    chk("fwdA", 32'(ForwardAE), rst ? 32'd0 : 32'(fwd_ref(RS1_E)));
    chk("fwdB", 32'(ForwardBE), rst ? 32'd0 : 32'(fwd_ref(RS2_E)));
    chk("timeout", 32'(hold_timeout), 32'(tmo_m));
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    chk("hold_cnt", 32'(hold_cnt_total), 32'(m_hold));
`endif
  endtask

  task automatic model_reset();
    hold_run = 0;
    tmo_m    = 1'b0;
    m_stall  = '0;
    m_flush  = '0;
    m_hold   = '0;
  endtask

  task automatic model_edge();
    logic [5:0] c;
    if (rst) begin
      model_reset();
    end else begin
      c = ctl_ref();
      m_stall = m_stall + CW'(c[4]);
      m_flush = m_flush + CW'(c[0]);
      if (hold_req) begin
        m_hold = m_hold + 1;
        if (hold_run < 65535) hold_run++;
        if (hold_run == MAXH) tmo_m = 1'b1;
      end else begin
        hold_run = 0;
      end
    end
  endtask

  task automatic cycle();
    #2 check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    {RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W} = '0;
    {RegWriteE, ResultSrcE, RegWriteM, RegWriteW, PCSrcE, hold_req} = '0;
  endtask

  task automatic rand_inputs(input bit allow_hold);
    RS1_D = 5'($urandom_range(0, 3)); RS2_D = 5'($urandom_range(0, 3));
    RS1_E = 5'($urandom_range(0, 3)); RS2_E = 5'($urandom_range(0, 3));
    RD_E  = 5'($urandom_range(0, 3)); RD_M  = 5'($urandom_range(0, 3));
    RD_W  = 5'($urandom_range(0, 3));
    RegWriteE  = 1'($urandom_range(0, 1)); ResultSrcE = 1'($urandom_range(0, 1));
    RegWriteM  = 1'($urandom_range(0, 1)); RegWriteW  = 1'($urandom_range(0, 1));
    PCSrcE     = ($urandom_range(0, 3) == 0);
    if (allow_hold) hold_req = hold_req ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    model_reset();
    clear_inputs();
    rst = 1'b1;
    // Inputs that would forward and stall if not held in reset.
    RS1_E = 5'd7; RD_M = 5'd7; RegWriteM = 1'b1; PCSrcE = 1'b1; hold_req = 1'b1;
    cycle();
    rst = 1'b0;
    clear_inputs();
    cycle();

    // Load-use: one-cycle stall, then bubble; RD_E=0 never stalls
    ResultSrcE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd5; RS1_D = 5'd5;
    cycle();
    ResultSrcE = 1'b0; RegWriteE = 1'b0; RD_E = 5'd0;
    cycle();
    ResultSrcE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd0; RS1_D = 5'd0;
    cycle();
    clear_inputs();

    // Forwarding priority M over W, then W only, then x0
    RD_M = 5'd7; RegWriteM = 1'b1; RD_W = 5'd7; RegWriteW = 1'b1; RS1_E = 5'd7; RS2_E = 5'd7;
    cycle();
    RegWriteM = 1'b0;
    cycle();
    RegWriteM = 1'b1; RD_M = 5'd0; RD_W = 5'd0; RS1_E = 5'd0; RS2_E = 5'd0;
    cycle();
    clear_inputs();

    // Branch alone, then branch with load-use
    PCSrcE = 1'b1;
    cycle();
    ResultSrcE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd3; RS2_D = 5'd3;
    cycle();
    clear_inputs();

    // Hold over a taken branch: flush lands on the first RUN cycle
    PCSrcE = 1'b1; hold_req = 1'b1;
    repeat (3) cycle();
    hold_req = 1'b0;
    cycle();
    clear_inputs();
    cycle();

    // Timeout: MAX_HOLD=4, six hold cycles; flag stays after release
    hold_req = 1'b1;
    repeat (6) cycle();
    hold_req = 1'b0;
    repeat (3) cycle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs(1'b1);
      cycle();
    end

    // Async reset in the middle of a hold, between edges
    clear_inputs();
    hold_req = 1'b1;
    repeat (2) cycle();
    #2 rst = 1'b1;
    model_reset();
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    #3 rst = 1'b0;
    hold_req = 1'b0;
    cycle();
    for (int i = 0; i < 100; i++) begin
      rand_inputs(1'b1);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
